// File: rtl/nodf_module_intf.sv
// Transaction monitor for an ap_start/ap_ready/ap_done/ap_continue handshake: latency and activity statistics.
// Optional feature: define NODF_MODULE_INTF_STALL_CNT_EN to add the stall_cnt output (count of WAIT cycles).
module nodf_module_intf #(
   parameter int CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ap_start,
   input  logic             ap_ready,
   input  logic             ap_done,
   input  logic             ap_continue,
   input  logic             finish,
   output logic [1:0]       state,
   output logic             busy,
   output logic [CNT_W-1:0] txn_cnt,
   output logic [CNT_W-1:0] ready_cnt,
   output logic [CNT_W-1:0] busy_cyc,
   output logic [CNT_W-1:0] last_lat,
   output logic [CNT_W-1:0] min_lat,
   output logic [CNT_W-1:0] max_lat,
   output logic             smp_valid,
   output logic [CNT_W-1:0] smp_lat,
   output logic             finished
`ifdef NODF_MODULE_INTF_STALL_CNT_EN
   ,
   output logic [CNT_W-1:0] stall_cnt
`endif
);

   // state    | meaning
   // S_IDLE   | no transaction in flight
   // S_RUN    | started, waiting for ap_done
   // S_WAIT   | done seen, waiting for ap_continue
   // S_FROZEN | run finished, statistics held until reset
   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_RUN    = 2'b01,
      S_WAIT   = 2'b10,
      S_FROZEN = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + ONE;
   endfunction

   state_t           state_q, state_d;
   logic [CNT_W-1:0] lat_q, lat_d, lat_inc, done_lat;
   logic             complete, hold;

   logic [CNT_W-1:0] txn_cnt_q, txn_cnt_d, ready_cnt_q, ready_cnt_d;
   logic [CNT_W-1:0] busy_cyc_q, busy_cyc_d, last_lat_q, last_lat_d;
   logic [CNT_W-1:0] min_lat_q, min_lat_d, max_lat_q, max_lat_d;
   logic [CNT_W-1:0] smp_lat_q, smp_lat_d;
   logic             smp_valid_q, smp_valid_d;

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         lat_q   <= '0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
      end
   end

   // lat_q counts cycles already spent; the completing cycle adds one more.
   always_comb begin
      state_d  = state_q;
      lat_d    = lat_q;
      lat_inc  = sat_inc(lat_q);
      done_lat = lat_inc;
      complete = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (ap_start) begin
               lat_d = ONE;
               if (ap_done && ap_continue) begin
                  complete = 1'b1;
                  done_lat = ONE;
               end else if (ap_done) begin
                  state_d = S_WAIT;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN, S_WAIT: begin
            lat_d = lat_inc;
            if ((state_q == S_RUN && ap_done && ap_continue) ||
                (state_q == S_WAIT && ap_continue)) begin
               complete = 1'b1;
               state_d  = ap_start ? S_RUN : S_IDLE;
               lat_d    = ONE;
            end else if (state_q == S_RUN && ap_done) begin
               state_d = S_WAIT;
            end
         end
         default: state_d = S_FROZEN;
      endcase
      if (finish) begin
         state_d  = S_FROZEN;
         complete = 1'b0;
      end
   end

   always_comb begin
      state    = state_q;
      busy     = (state_q == S_RUN) || (state_q == S_WAIT);
      finished = (state_q == S_FROZEN);
   end

   assign hold = finish || (state_q == S_FROZEN);

   // busy_cyc includes the accepting start cycle seen from IDLE.
   always_comb begin
      txn_cnt_d   = txn_cnt_q;
      ready_cnt_d = ready_cnt_q;
      busy_cyc_d  = busy_cyc_q;
      last_lat_d  = last_lat_q;
      min_lat_d   = min_lat_q;
      max_lat_d   = max_lat_q;
      smp_lat_d   = smp_lat_q;
      smp_valid_d = 1'b0;
      if (!hold) begin
         if (ap_ready) ready_cnt_d = sat_inc(ready_cnt_q);
         if (state_q != S_IDLE || ap_start) busy_cyc_d = sat_inc(busy_cyc_q);
         if (complete) begin
            txn_cnt_d   = sat_inc(txn_cnt_q);
            last_lat_d  = done_lat;
            smp_valid_d = 1'b1;
            smp_lat_d   = done_lat;
            if (txn_cnt_q == '0) begin
               min_lat_d = done_lat;
               max_lat_d = done_lat;
            end else begin
               if (done_lat < min_lat_q) min_lat_d = done_lat;
               if (done_lat > max_lat_q) max_lat_d = done_lat;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         txn_cnt_q   <= '0;
         ready_cnt_q <= '0;
         busy_cyc_q  <= '0;
         last_lat_q  <= '0;
         min_lat_q   <= '0;
         max_lat_q   <= '0;
         smp_lat_q   <= '0;
         smp_valid_q <= 1'b0;
      end else begin
         txn_cnt_q   <= txn_cnt_d;
         ready_cnt_q <= ready_cnt_d;
         busy_cyc_q  <= busy_cyc_d;
         last_lat_q  <= last_lat_d;
         min_lat_q   <= min_lat_d;
         max_lat_q   <= max_lat_d;
         smp_lat_q   <= smp_lat_d;
         smp_valid_q <= smp_valid_d;
      end
   end

   assign txn_cnt   = txn_cnt_q;
   assign ready_cnt = ready_cnt_q;
   assign busy_cyc  = busy_cyc_q;
   assign last_lat  = last_lat_q;
   assign min_lat   = min_lat_q;
   assign max_lat   = max_lat_q;
   assign smp_lat   = smp_lat_q;
   assign smp_valid = smp_valid_q;

`ifdef NODF_MODULE_INTF_STALL_CNT_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!hold && state_q == S_WAIT) stall_cnt_d = sat_inc(stall_cnt_q);
   end

   always_ff @(posedge clock) begin
      if (reset) stall_cnt_q <= '0;
      else       stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_nodf_module_intf.sv
// Bench for nodf_module_intf: per-cycle vector table plus directed sequences for
// saturation, freeze, finish/completion collision and reset-over-finish.
module tb_nodf_module_intf;

   logic clock = 1'b0;
   logic reset, ap_start, ap_ready, ap_done, ap_continue, finish;

   logic [1:0]  state, state_s;
   logic        busy, busy_s, smp_valid, smp_valid_s, finished, finished_s;
   logic [31:0] txn_cnt, ready_cnt, busy_cyc, last_lat, min_lat, max_lat, smp_lat;
   logic [3:0]  txn_cnt_s, ready_cnt_s, busy_cyc_s, last_lat_s, min_lat_s, max_lat_s, smp_lat_s;
`ifdef NODF_MODULE_INTF_STALL_CNT_EN
   logic [31:0] stall_cnt;
   logic [3:0]  stall_cnt_s;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock = ~clock;

   nodf_module_intf #(.CNT_W(32)) dut (
      .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
      .state(state), .busy(busy), .txn_cnt(txn_cnt), .ready_cnt(ready_cnt),
      .busy_cyc(busy_cyc), .last_lat(last_lat), .min_lat(min_lat), .max_lat(max_lat),
      .smp_valid(smp_valid), .smp_lat(smp_lat), .finished(finished)
`ifdef NODF_MODULE_INTF_STALL_CNT_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   nodf_module_intf #(.CNT_W(4)) dut_s (
      .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
      .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
      .state(state_s), .busy(busy_s), .txn_cnt(txn_cnt_s), .ready_cnt(ready_cnt_s),
      .busy_cyc(busy_cyc_s), .last_lat(last_lat_s), .min_lat(min_lat_s), .max_lat(max_lat_s),
      .smp_valid(smp_valid_s), .smp_lat(smp_lat_s), .finished(finished_s)
`ifdef NODF_MODULE_INTF_STALL_CNT_EN
      , .stall_cnt(stall_cnt_s)
`endif
   );

   typedef struct {
      logic        s, r, d, c, f;
      logic [1:0]  st;
      logic        bsy, sv;
      logic [31:0] lat, txn;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic s, input logic r, input logic d, input logic c, input logic f);
      ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0, 0, 1, 0);
      reset = 1'b0;
   endtask

   logic [31:0] hold_busy, hold_ready;

   initial begin
      reset = 1'b1; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0;
      //            s  r  d  c  f   st     bsy sv  lat txn
      tbl[0]  = '{1, 0, 0, 1, 0, 2'd1, 1, 0, 0, 0};
      tbl[1]  = '{0, 0, 0, 1, 0, 2'd1, 1, 0, 0, 0};
      tbl[2]  = '{0, 1, 0, 1, 0, 2'd1, 1, 0, 0, 0};
      tbl[3]  = '{0, 0, 1, 1, 0, 2'd0, 0, 1, 4, 1};
      tbl[4]  = '{0, 0, 0, 1, 0, 2'd0, 0, 0, 0, 1};
      tbl[5]  = '{1, 0, 1, 1, 0, 2'd0, 0, 1, 1, 2};
      tbl[6]  = '{0, 1, 1, 1, 0, 2'd0, 0, 0, 0, 2};
      tbl[7]  = '{1, 0, 0, 0, 0, 2'd1, 1, 0, 0, 2};
      tbl[8]  = '{0, 0, 0, 0, 0, 2'd1, 1, 0, 0, 2};
      tbl[9]  = '{0, 0, 1, 0, 0, 2'd2, 1, 0, 0, 2};
      tbl[10] = '{0, 0, 0, 0, 0, 2'd2, 1, 0, 0, 2};
      tbl[11] = '{0, 0, 0, 0, 0, 2'd2, 1, 0, 0, 2};
      tbl[12] = '{0, 0, 0, 1, 0, 2'd0, 0, 1, 6, 3};
      tbl[13] = '{1, 0, 0, 1, 0, 2'd1, 1, 0, 0, 3};
      tbl[14] = '{1, 0, 1, 1, 0, 2'd1, 1, 1, 2, 4};
      tbl[15] = '{0, 0, 1, 1, 0, 2'd0, 0, 1, 2, 5};

      step(0, 0, 0, 1, 0);
      step(0, 0, 0, 1, 0);
      reset = 1'b0;
      chk("reset_state", 32'(state), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_txn", txn_cnt, 0);
      chk("reset_min", min_lat, 0);
      chk("reset_max", max_lat, 0);
      chk("reset_smp_valid", 32'(smp_valid), 0);
      chk("reset_finished", 32'(finished), 0);

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].s, tbl[i].r, tbl[i].d, tbl[i].c, tbl[i].f);
         chk($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
         chk($sformatf("v%0d_smp_valid", i), 32'(smp_valid), 32'(tbl[i].sv));
         chk($sformatf("v%0d_txn", i), txn_cnt, tbl[i].txn);
         if (tbl[i].sv) chk($sformatf("v%0d_smp_lat", i), smp_lat, tbl[i].lat);
      end
      chk("tbl_busy_cyc", busy_cyc, 14);
      chk("tbl_ready_cnt", ready_cnt, 2);
      chk("tbl_min_lat", min_lat, 1);
      chk("tbl_max_lat", max_lat, 6);
      chk("tbl_last_lat", last_lat, 2);
      chk("tbl_small_txn", 32'(txn_cnt_s), 5);
`ifdef NODF_MODULE_INTF_STALL_CNT_EN
      chk("tbl_stall_cnt", stall_cnt, 3);
`endif

      // ready counting with no transactions, then saturation of the 4-bit instance
      do_reset();
      for (int i = 0; i < 5; i++) step(0, 1, 0, 1, 0);
      chk("rdy5_ready_cnt", ready_cnt, 5);
      chk("rdy5_txn", txn_cnt, 0);
      chk("rdy5_state", 32'(state), 0);
      for (int i = 0; i < 15; i++) step(0, 1, 0, 1, 0);
      chk("rdy20_ready_cnt", ready_cnt, 20);
      chk("rdy20_small_sat", 32'(ready_cnt_s), 15);

      // latencies 2 and 5, then finish during a third transaction
      do_reset();
      step(1, 0, 0, 1, 0);
      step(0, 0, 1, 1, 0);
      chk("frz_lat2", smp_lat, 2);
      step(1, 0, 0, 1, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
      step(0, 0, 1, 1, 0);
      chk("frz_lat5", smp_lat, 5);
      step(1, 0, 0, 1, 0);
      step(0, 0, 0, 1, 1);
      chk("frz_state", 32'(state), 3);
      chk("frz_finished", 32'(finished), 1);
      chk("frz_busy", 32'(busy), 0);
      chk("frz_min", min_lat, 2);
      chk("frz_max", max_lat, 5);
      chk("frz_txn", txn_cnt, 2);
      chk("frz_busy_cyc", busy_cyc, 8);
      hold_busy = busy_cyc;
      hold_ready = ready_cnt;
      for (int i = 0; i < 5; i++) begin
         step(1, 1, 1, 1, 0);
         chk($sformatf("frz_hold%0d_smp_valid", i), 32'(smp_valid), 0);
      end
      chk("frz_hold_state", 32'(state), 3);
      chk("frz_hold_txn", txn_cnt, 2);
      chk("frz_hold_busy_cyc", busy_cyc, hold_busy);
      chk("frz_hold_ready", ready_cnt, hold_ready);
      chk("frz_hold_ready_zero", ready_cnt, 0);

      // finish collides with completion: finish wins
      do_reset();
      step(1, 0, 0, 1, 0);
      step(0, 0, 1, 1, 1);
      chk("col_state", 32'(state), 3);
      chk("col_smp_valid", 32'(smp_valid), 0);
      chk("col_txn", txn_cnt, 0);

      // reset beats finish and discards the in-flight transaction
      do_reset();
      step(1, 0, 0, 1, 0);
      reset = 1'b1;
      step(0, 0, 1, 1, 1);
      reset = 1'b0;
      chk("rst_state", 32'(state), 0);
      chk("rst_finished", 32'(finished), 0);
      chk("rst_smp_valid", 32'(smp_valid), 0);
      chk("rst_txn", txn_cnt, 0);
      chk("rst_busy_cyc", busy_cyc, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
